rf_wb_scheduler: RTL

- Shares the register file's single write port between two producers: the in-order pipeline writeback (WB stage) and the long-latency unit (mult/div/load-miss) result stream.
- Keeps a 32-bit pending-write scoreboard so decode stalls on RAW/WAW hazards against outstanding long-latency results.
- Sits between the WB stage, the long-latency unit and the register file write port (write_en/addr_d/data_d).

---
 rtl/rf_wb_scheduler_pkg.sv | 32 +++
 rtl/rf_wb_fifo.sv | 68 ++++++
 rtl/rf_wb_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_scheduler_pkg.sv
// rtl/rf_wb_scheduler_pkg.sv - shared widths, entry type and helpers for the RF write-port scheduler
//
// Purpose: common definitions for rf_wb_scheduler and its result FIFO.
//   REG_ADDR_W / DATA_W : register address and data widths
//   REG_ZERO            : hard-wired zero register index
//   rf_entry_t          : buffered long-latency result {addr, data}
//   reg_onehot()        : one-hot register mask with r0 suppressed

package rf_wb_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_entry_t;

  localparam int ENTRY_W = $bits(rf_entry_t);

  // r0 can never be pending, so its bit is always left clear.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (a != REG_ZERO) m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - synchronous FIFO buffering long-latency results
//
// Purpose: DEPTH-entry (power of two, >=2) FIFO with async active-high reset.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   push_i, push_data_i   write request and data (ignored when full unless popping)
//   pop_i, pop_data_o     read request and head data (head valid while !empty_o)
//   full_o, empty_o       status flags
//   count_o               occupancy, 0..DEPTH

module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full FIFO can still take a push when the head leaves in the same cycle:
  // the write lands in the slot being vacated, which is read before the edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - arbitrates the register-file write port between WB and long-latency results
//
// Purpose: the pipeline writeback normally owns the single RF write port; long-latency
// results are buffered and written when the port is free. A pending-write scoreboard
// stalls decode on hazards, and a starvation counter freezes the pipeline (wb_hold_o)
// when the buffer has been blocked for STARVE_LIMIT consecutive cycles.
// Ports:
//   clk_i, reset_i                        clock, asynchronous active-high reset
//   wb_valid_i, wb_addr_i, wb_data_i      pipeline writeback request
//   lu_issue_i, lu_issue_addr_i           long-latency issue, reserves destination
//   lu_valid_i, lu_ready_o, lu_addr_i,
//   lu_data_i                             long-latency result stream
//   dec_addr_s_i, dec_addr_t_i,
//   dec_addr_d_i, dec_stall_o             decode hazard query
//   wb_hold_o                             pipeline freeze
//   rf_write_en_o, rf_addr_d_o, rf_data_d_o  register file write port

module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  lu_issue_i,
  input  logic [REG_ADDR_W-1:0] lu_issue_addr_i,
  input  logic                  lu_valid_i,
  output logic                  lu_ready_o,
  input  logic [REG_ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0]     lu_data_i,
  input  logic [REG_ADDR_W-1:0] dec_addr_s_i,
  input  logic [REG_ADDR_W-1:0] dec_addr_t_i,
  input  logic [REG_ADDR_W-1:0] dec_addr_d_i,
  output logic                  dec_stall_o,
  output logic                  wb_hold_o,
  output logic                  rf_write_en_o,
  output logic [REG_ADDR_W-1:0] rf_addr_d_o,
  output logic [DATA_W-1:0]     rf_data_d_o
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_rdata;
  rf_entry_t           push_entry, head;

  logic                wb_own;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                wb_hold_q, wb_hold_d;

  // Port ownership. A held pipeline never owns the port, even if it (illegally)
  // presents a request; r0 writes are discarded and leave the port to the FIFO.
  assign wb_own   = ~wb_hold_q & wb_valid_i & (wb_addr_i != REG_ZERO);
  assign fifo_pop = ~wb_own & ~fifo_empty;

  // Ready is a pure function of registered occupancy, so there is no
  // combinational path from the pop decision into lu_ready_o.
  assign lu_ready_o = ~fifo_full;

  // r0 results complete the handshake but are never buffered.
  assign fifo_push       = lu_valid_i & ~fifo_full & (lu_addr_i != REG_ZERO);
  assign push_entry.addr = lu_addr_i;
  assign push_entry.data = lu_data_i;
  assign head            = rf_entry_t'(fifo_rdata);

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Write-port mux: zero-latency pipeline write, otherwise the FIFO head.
  always_comb begin
    rf_write_en_o = 1'b0;
    rf_addr_d_o   = REG_ZERO;
    rf_data_d_o   = '0;
    if (wb_own) begin
      rf_write_en_o = 1'b1;
      rf_addr_d_o   = wb_addr_i;
      rf_data_d_o   = wb_data_i;
    end else if (fifo_pop) begin
      rf_write_en_o = 1'b1;
      rf_addr_d_o   = head.addr;
      rf_data_d_o   = head.data;
    end
  end

  // Scoreboard: a new reservation beats the retirement of the same register,
  // because the newly issued op will write it again later.
  always_comb begin
    set_mask  = lu_issue_i ? reg_onehot(lu_issue_addr_i) : '0;
    clr_mask  = fifo_pop ? reg_onehot(head.addr) : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  assign dec_stall_o = (pending_q[dec_addr_s_i] & (dec_addr_s_i != REG_ZERO)) |
                       (pending_q[dec_addr_t_i] & (dec_addr_t_i != REG_ZERO)) |
                       (pending_q[dec_addr_d_i] & (dec_addr_d_i != REG_ZERO));

  // Starvation: count consecutive cycles where a buffered result lost the port.
  // The hold is raised at the same edge the count reaches the limit, and once
  // up it is released only at the edge following a cycle with an empty FIFO.
  always_comb begin
    starve_d = '0;
    if (wb_own && !fifo_empty) begin
      starve_d = (starve_q == STARVE_W'(STARVE_LIMIT)) ? starve_q
                                                       : starve_q + STARVE_W'(1);
    end
    if (wb_hold_q) begin
      wb_hold_d = (fifo_count != '0);
    end else begin
      wb_hold_d = (starve_d == STARVE_W'(STARVE_LIMIT));
    end
  end

  assign wb_hold_o = wb_hold_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= '0;
      starve_q  <= '0;
      wb_hold_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      wb_hold_q <= wb_hold_d;
    end
  end

endmodule
